// File: rtl/debug_cmd_arbiter_pkg.sv
// Shared types and constants for the debug command arbiter.
package debug_arb_pkg;

    localparam int DBG_ADDR_W = 8;
    localparam int DBG_DATA_W = 32;
    localparam int MAX_N_REQ  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

    // Width of a requester index; kept at least 1 so the index is never zero-width.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_cmd_arbiter_if.sv
// Command/response channel between the arbiter and the CPU debug port.
interface debug_cmd_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] rsp_data;

    // Arbiter side: issues commands, receives the late response data.
    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_data,
        input  cmd_ready, rsp_data
    );

    // Debug port side.
    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_data,
        output cmd_ready, rsp_data
    );
endinterface

// File: rtl/debug_cmd_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or above ptr, wrapping.
module rr_picker
    import debug_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDW   = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             found,
    output logic [IDW-1:0]   idx
);

    // Scan upward from ptr; the first hit wins.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/debug_cmd_arbiter.sv
// Shares one CPU debug command port among N_REQ requesters, round-robin,
// one outstanding command at a time, with an optional per-requester lock.
//
//   state | meaning
//   IDLE  | no grant held; pick the next requester from rr_ptr
//   CMD   | grantee's command mirrored onto the debug port until it fires
//   RSP   | one-cycle response strobe to the grantee; lock decides CMD or IDLE
module debug_cmd_arbiter
    import debug_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = DBG_ADDR_W,
    parameter int DATA_W = DBG_DATA_W,
    localparam int IDW   = id_width(N_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0]               req_wr,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]               req_lock,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [DATA_W-1:0]              rsp_data,
    debug_cmd_arbiter_if.master            dbg,
    output logic [IDW-1:0]                 grant_id,
    output logic                           busy
);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            wr_q, wr_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  next_ptr;

    rr_picker #(.N_REQ(N_REQ), .IDW(IDW)) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign next_ptr = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + IDW'(1);

    // Next-state logic: grant selection, fire detection, lock handling.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        wr_d     = wr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (!req_valid[grant_q]) begin
                    // Requester withdrew before firing: drop the grant silently.
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (dbg.cmd_ready) begin
                    state_d = RSP;
                    wr_d    = req_wr[grant_q];
                end
            end
            RSP: begin
                if (req_lock[grant_q]) begin
                    state_d = CMD;
                end else begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and grant registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_q     <= wr_d;
        end
    end

    // Port muxing: command path only open in CMD, response path only in RSP.
    always_comb begin
        dbg.cmd_valid = 1'b0;
        dbg.cmd_wr    = 1'b0;
        dbg.cmd_addr  = '0;
        dbg.cmd_data  = '0;
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_data      = '0;
        if (state_q == CMD) begin
            dbg.cmd_valid      = req_valid[grant_q];
            dbg.cmd_wr         = req_wr[grant_q];
            dbg.cmd_addr       = req_addr[grant_q];
            dbg.cmd_data       = req_data[grant_q];
            req_ready[grant_q] = dbg.cmd_ready;
        end
        if (state_q == RSP) begin
            rsp_valid[grant_q] = 1'b1;
            rsp_data           = wr_q ? '0 : dbg.rsp_data;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_debug_cmd_arbiter.sv
// Directed bench for debug_cmd_arbiter with hand-computed expectations.
module tb_debug_cmd_arbiter;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic                          clk;
    logic                          reset;
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ-1:0]              req_wr;
    logic [N_REQ-1:0][ADDR_W-1:0]  req_addr;
    logic [N_REQ-1:0][DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]              req_lock;
    logic [N_REQ-1:0]              rsp_valid;
    logic [DATA_W-1:0]             rsp_data;
    logic [0:0]                    grant_id;
    logic                          busy;

    int n_cmp = 0;
    int n_err = 0;

    debug_cmd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg_if ();

    debug_cmd_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .dbg       (dbg_if),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b0;
        req_valid        = '0;
        req_wr           = '0;
        req_addr         = '0;
        req_data         = '0;
        req_lock         = '0;
        dbg_if.cmd_ready = 1'b0;
        dbg_if.rsp_data  = '0;

        // Reset state
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_cmd_valid", dbg_if.cmd_valid, 0);
        reset = 1'b1;

        // Single read by req0
        cyc();
        req_valid        = 2'b01;
        req_addr[0]      = 8'h04;
        dbg_if.cmd_ready = 1'b1;
        dbg_if.rsp_data  = 32'hDEADBEEF;
        @(negedge clk);
        check_eq("rd_idle_cmd_valid", dbg_if.cmd_valid, 0);
        check_eq("rd_idle_busy", busy, 0);
        cyc();
        @(negedge clk);
        check_eq("rd_cmd_valid", dbg_if.cmd_valid, 1);
        check_eq("rd_cmd_addr", dbg_if.cmd_addr, 8'h04);
        check_eq("rd_cmd_wr", dbg_if.cmd_wr, 0);
        check_eq("rd_req_ready", req_ready, 2'b01);
        check_eq("rd_grant", grant_id, 0);
        cyc();
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("rd_rsp_valid", rsp_valid, 2'b01);
        check_eq("rd_rsp_data", rsp_data, 32'hDEADBEEF);
        check_eq("rd_rsp_cmd_valid", dbg_if.cmd_valid, 0);
        cyc();
        @(negedge clk);
        check_eq("rd_after_rsp_valid", rsp_valid, 0);
        check_eq("rd_after_rsp_data", rsp_data, 0);
        check_eq("rd_after_busy", busy, 0);

        // Fresh pointer for contention
        reset = 1'b0;
        #2;
        reset = 1'b1;

        // Contention, no lock: grants alternate 0,1,0,1 at one command per 3 cycles
        cyc();
        req_valid       = 2'b11;
        req_addr[0]     = 8'h10;
        req_addr[1]     = 8'h11;
        dbg_if.rsp_data = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("ct%0d_idle_busy", i), busy, 0);
            cyc();
            @(negedge clk);
            check_eq($sformatf("ct%0d_grant", i), grant_id, i % 2);
            check_eq($sformatf("ct%0d_addr", i), dbg_if.cmd_addr, 8'h10 + (i % 2));
            check_eq($sformatf("ct%0d_req_ready", i), req_ready, (i % 2) ? 2'b10 : 2'b01);
            cyc();
            @(negedge clk);
            check_eq($sformatf("ct%0d_rsp_valid", i), rsp_valid, (i % 2) ? 2'b10 : 2'b01);
            check_eq($sformatf("ct%0d_rsp_data", i), rsp_data, 32'h12345678);
            cyc();
        end
        req_valid = 2'b00;

        // Lock sequence: req1 holds the grant for three commands, req0 waits
        @(negedge clk);
        cyc();
        req_valid = 2'b10;
        req_lock  = 2'b10;
        cyc();
        req_valid = 2'b11;
        @(negedge clk);
        check_eq("lk1_grant", grant_id, 1);
        check_eq("lk1_req_ready", req_ready, 2'b10);
        cyc();
        @(negedge clk);
        check_eq("lk1_rsp_valid", rsp_valid, 2'b10);
        cyc();
        @(negedge clk);
        check_eq("lk2_grant", grant_id, 1);
        check_eq("lk2_req_ready", req_ready, 2'b10);
        cyc();
        @(negedge clk);
        check_eq("lk2_rsp_valid", rsp_valid, 2'b10);
        cyc();
        req_lock = 2'b00;
        @(negedge clk);
        check_eq("lk3_grant", grant_id, 1);
        check_eq("lk3_req_ready", req_ready, 2'b10);
        cyc();
        @(negedge clk);
        check_eq("lk3_rsp_valid", rsp_valid, 2'b10);
        cyc();
        req_valid = 2'b01;
        @(negedge clk);
        check_eq("lk_idle_busy", busy, 0);
        cyc();
        @(negedge clk);
        check_eq("lk_next_grant", grant_id, 0);
        check_eq("lk_next_req_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("lk_next_rsp_valid", rsp_valid, 2'b01);
        cyc();

        // Backpressure: write held for 5 cycles with ready low
        req_valid        = 2'b01;
        req_wr           = 2'b01;
        req_addr[0]      = 8'h00;
        req_data[0]      = 32'h00010000;
        dbg_if.cmd_ready = 1'b0;
        dbg_if.rsp_data  = 32'hDEADBEEF;
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("bp%0d_req_ready", i), req_ready, 2'b00);
            check_eq($sformatf("bp%0d_cmd_valid", i), dbg_if.cmd_valid, 1);
            check_eq($sformatf("bp%0d_cmd_wr", i), dbg_if.cmd_wr, 1);
            check_eq($sformatf("bp%0d_cmd_addr", i), dbg_if.cmd_addr, 8'h00);
            check_eq($sformatf("bp%0d_cmd_data", i), dbg_if.cmd_data, 32'h00010000);
            cyc();
        end
        dbg_if.cmd_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_fire_req_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        req_wr    = 2'b00;
        @(negedge clk);
        check_eq("bp_rsp_valid", rsp_valid, 2'b01);
        check_eq("bp_rsp_data_wr", rsp_data, 32'h0);
        cyc();

        // Reset asserted while in CMD
        req_valid        = 2'b10;
        dbg_if.cmd_ready = 1'b0;
        cyc();
        @(negedge clk);
        check_eq("rc_pre_grant", grant_id, 1);
        check_eq("rc_pre_cmd_valid", dbg_if.cmd_valid, 1);
        #1;
        reset = 1'b0;
        #1;
        check_eq("rc_cmd_valid", dbg_if.cmd_valid, 0);
        check_eq("rc_grant", grant_id, 0);
        check_eq("rc_busy", busy, 0);
        check_eq("rc_req_ready", req_ready, 0);
        req_valid = 2'b00;
        cyc();
        reset = 1'b1;
        cyc();
        @(negedge clk);
        check_eq("rc_post_rsp_valid", rsp_valid, 0);
        check_eq("rc_post_grant", grant_id, 0);
        check_eq("rc_post_busy", busy, 0);

        // Abort: req0 drops valid in CMD; pointer moves past it
        cyc();
        req_valid = 2'b01;
        cyc();
        @(negedge clk);
        check_eq("ab_grant", grant_id, 0);
        check_eq("ab_busy_cmd", busy, 1);
        cyc();
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("ab_cmd_valid_drop", dbg_if.cmd_valid, 0);
        cyc();
        @(negedge clk);
        check_eq("ab_idle_busy", busy, 0);
        check_eq("ab_idle_rsp_valid", rsp_valid, 0);
        cyc();
        req_valid = 2'b11;
        @(negedge clk);
        check_eq("ab_no_late_rsp", rsp_valid, 0);
        cyc();
        @(negedge clk);
        check_eq("ab_ptr_grant", grant_id, 1);
        req_valid = 2'b00;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
